jtframe_sort_solve: RTL and testbench

Debug-side companion to the 4-bit nibble reordering stage. The reordering stage applies one of 24 bit orderings selected by a 5-bit code. This block works in the opposite direction:
- It watches pairs of known reference nibbles and the reordered nibbles.
- It eliminates candidate codes until the ordering is identified.
- It latches the winning code and drives a registered inverse reorderer that restores original bit order.
It is used during board bring-up to recover unknown ROM/data-line orderings.

---
 rtl/jtframe_sort_solve.sv | 219 +++++++++++++++++++++
 tb/tb_jtframe_sort_solve.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_sort_solve.sv
// jtframe_sort_solve
//   Recovers the unknown 4-bit ordering applied by the nibble reordering
//   stage. Known reference nibbles are compared against their reordered
//   copies; candidate codes that disagree are eliminated over a fixed window
//   of samples. The surviving code is latched and drives a registered
//   inverse reorderer that restores the original bit order.
//
// Ports
//   clk, rst            system clock, synchronous active-high reset
//   start               one-cycle pulse, begins (or restarts) a search
//   sample_valid        ref_nib/obs_nib carry a sample this cycle
//   ref_nib, obs_nib    known nibble and its reordered copy
//   busy                search in progress (COLLECT or RESOLVE)
//   done                one-cycle pulse when a search ends
//   found, ambig        last search left exactly one / two or more candidates
//   code                locked code (0x00..0x17)
//   debug_bus           {3'b000, code}
//   din, dout           reordered data in, restored data out (1-cycle latency)

module jtframe_sort_solve #(
    parameter int unsigned WINDOW = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       sample_valid,
    input  logic [3:0] ref_nib,
    input  logic [3:0] obs_nib,
    output logic       busy,
    output logic       done,
    output logic       found,
    output logic       ambig,
    output logic [4:0] code,
    output logic [7:0] debug_bus,
    input  logic [3:0] din,
    output logic [3:0] dout
);

    localparam logic [7:0] WIN = 8'(WINDOW);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        RESOLVE = 2'd2
    } state_t;

    // Source index for each output bit, packed {out3, out2, out1, out0}.
    function automatic logic [7:0] src_of(input logic [4:0] c);
        logic [7:0] s;
        case (c)
            5'h00: s = {2'd3, 2'd2, 2'd1, 2'd0};
            5'h01: s = {2'd3, 2'd2, 2'd0, 2'd1};
            5'h02: s = {2'd3, 2'd1, 2'd2, 2'd0};
            5'h03: s = {2'd3, 2'd1, 2'd0, 2'd2};
            5'h04: s = {2'd3, 2'd0, 2'd1, 2'd2};
            5'h05: s = {2'd3, 2'd0, 2'd2, 2'd1};
            5'h06: s = {2'd2, 2'd3, 2'd1, 2'd0};
            5'h07: s = {2'd2, 2'd3, 2'd0, 2'd1};
            5'h08: s = {2'd2, 2'd1, 2'd3, 2'd0};
            5'h09: s = {2'd2, 2'd1, 2'd0, 2'd3};
            5'h0a: s = {2'd2, 2'd0, 2'd1, 2'd3};
            5'h0b: s = {2'd2, 2'd0, 2'd3, 2'd1};
            5'h0c: s = {2'd1, 2'd2, 2'd3, 2'd0};
            5'h0d: s = {2'd1, 2'd2, 2'd0, 2'd3};
            5'h0e: s = {2'd1, 2'd3, 2'd2, 2'd0};
            5'h0f: s = {2'd1, 2'd3, 2'd0, 2'd2};
            5'h10: s = {2'd1, 2'd0, 2'd3, 2'd2};
            5'h11: s = {2'd1, 2'd0, 2'd2, 2'd3};
            5'h12: s = {2'd0, 2'd2, 2'd1, 2'd3};
            5'h13: s = {2'd0, 2'd2, 2'd3, 2'd1};
            5'h14: s = {2'd0, 2'd1, 2'd2, 2'd3};
            5'h15: s = {2'd0, 2'd1, 2'd3, 2'd2};
            5'h16: s = {2'd0, 2'd3, 2'd1, 2'd2};
            5'h17: s = {2'd0, 2'd3, 2'd2, 2'd1};
            default: s = {2'd3, 2'd2, 2'd1, 2'd0};
        endcase
        return s;
    endfunction

    function automatic logic [3:0] fwd(input logic [4:0] c, input logic [3:0] x);
        logic [7:0] s;
        logic [3:0] y;
        s = src_of(c);
        y = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            y[k] = x[s[2*k +: 2]];
        end
        return y;
    endfunction

    function automatic logic [3:0] inv(input logic [4:0] c, input logic [3:0] x);
        logic [7:0] s;
        logic [3:0] y;
        s = src_of(c);
        y = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            y[s[2*k +: 2]] = x[k];
        end
        return y;
    endfunction

    state_t      state_q, state_d;
    logic [23:0] mask_q, mask_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic        found_q, found_d;
    logic        ambig_q, ambig_d;
    logic [4:0]  code_q, code_d;
    logic [3:0]  dout_q;

    logic [23:0] match;
    logic [4:0]  pop;
    logic [4:0]  low_idx;
    logic        seen;

    // Per-candidate agreement with the current sample, plus popcount and
    // lowest surviving index of the registered mask.
    always_comb begin
        match   = '0;
        pop     = '0;
        low_idx = '0;
        seen    = 1'b0;
        for (int unsigned c = 0; c < 24; c++) begin
            match[c] = (fwd(5'(c), ref_nib) == obs_nib);
            pop      = pop + {4'b0, mask_q[c]};
            if (mask_q[c] && !seen) begin
                low_idx = 5'(c);
                seen    = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        found_d = found_q;
        ambig_d = ambig_q;
        code_d  = code_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mask_d  = '1;
                    cnt_d   = '0;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                // start has priority: a sample in the same cycle is dropped.
                // The window-complete check waits one cycle so the last
                // elimination is already in mask_q when RESOLVE reads it.
                if (start) begin
                    mask_d = '1;
                    cnt_d  = '0;
                end else if (cnt_q == WIN) begin
                    state_d = RESOLVE;
                end else if (sample_valid) begin
                    mask_d = mask_q & match;
                    cnt_d  = cnt_q + 8'd1;
                end
            end
            RESOLVE: begin
                if (start) begin
                    mask_d  = '1;
                    cnt_d   = '0;
                    state_d = COLLECT;
                end else begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                    if (pop == 5'd1) begin
                        found_d = 1'b1;
                        ambig_d = 1'b0;
                        code_d  = low_idx;
                    end else if (pop >= 5'd2) begin
                        found_d = 1'b0;
                        ambig_d = 1'b1;
                        code_d  = low_idx;
                    end else begin
                        found_d = 1'b0;
                        ambig_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mask_q  <= '1;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            found_q <= 1'b0;
            ambig_q <= 1'b0;
            code_q  <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            found_q <= found_d;
            ambig_q <= ambig_d;
            code_q  <= code_d;
            dout_q  <= inv(code_q, din);
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign found     = found_q;
    assign ambig     = ambig_q;
    assign code      = code_q;
    assign debug_bus = {3'b000, code_q};
    assign dout      = dout_q;

endmodule

// File: tb/tb_jtframe_sort_solve.sv
// Self-checking bench for jtframe_sort_solve. Search outcomes are pushed to
// a scoreboard queue when a search is launched and popped when done pulses.
module tb_jtframe_sort_solve;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       sample_valid = 1'b0;
    logic [3:0] ref_nib = '0;
    logic [3:0] obs_nib = '0;
    logic       busy, done, found, ambig;
    logic [4:0] code;
    logic [7:0] debug_bus;
    logic [3:0] din = '0;
    logic [3:0] dout;

    int checks   = 0;
    int failures = 0;

    jtframe_sort_solve #(.WINDOW(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .sample_valid (sample_valid),
        .ref_nib      (ref_nib),
        .obs_nib      (obs_nib),
        .busy         (busy),
        .done         (done),
        .found        (found),
        .ambig        (ambig),
        .code         (code),
        .debug_bus    (debug_bus),
        .din          (din),
        .dout         (dout)
    );

    always #5 clk = ~clk;

    // Hex digit n (n=0 is out[0]) is the source bit index for out[n].
    logic [15:0] tbl [24] = '{
        16'h3210, 16'h3201, 16'h3120, 16'h3102, 16'h3012, 16'h3021,
        16'h2310, 16'h2301, 16'h2130, 16'h2103, 16'h2013, 16'h2031,
        16'h1230, 16'h1203, 16'h1320, 16'h1302, 16'h1032, 16'h1023,
        16'h0213, 16'h0231, 16'h0123, 16'h0132, 16'h0312, 16'h0321
    };

    function automatic logic [3:0] model_fwd(input logic [4:0] c, input logic [3:0] x);
        logic [15:0] row;
        logic [3:0]  dig;
        logic [3:0]  y;
        row = tbl[c];
        y = '0;
        for (int k = 0; k < 4; k++) begin
            dig  = row[4*k +: 4];
            y[k] = x[dig[1:0]];
        end
        return y;
    endfunction

    typedef struct packed {
        logic       f;
        logic       a;
        logic [4:0] c;
    } res_t;

    res_t exp_q[$];

    typedef struct {
        logic [4:0] fcode;   // ordering used to build obs
        int         mode;    // 0: ref 1,2,4,8  1: ref=obs=F  2: ref 1 obs 3
        res_t       expect_r;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 expected done=0");
            end else begin
                res_t e;
                e = exp_q.pop_front();
                chk("found", int'(found), int'(e.f));
                chk("ambig", int'(ambig), int'(e.a));
                chk("code", int'(code), int'(e.c));
                chk("debug_bus", int'(debug_bus), int'({3'b000, e.c}));
            end
        end
    end

    task automatic set_sample(input logic [4:0] fc, input int mode, input int i);
        logic [3:0] r;
        case (mode)
            0: begin r = 4'(1 << (i % 4)); ref_nib = r; obs_nib = model_fwd(fc, r); end
            1: begin ref_nib = 4'hF; obs_nib = 4'hF; end
            default: begin ref_nib = 4'h1; obs_nib = 4'h3; end
        endcase
    endtask

    task automatic drive_samples(input logic [4:0] fc, input int mode, input int n);
        for (int i = 0; i < n; i++) begin
            set_sample(fc, mode, i);
            sample_valid = 1'b1;
            @(negedge clk);
        end
        sample_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at the negedge after the last sample edge (e16); done is
    // expected high after edge e18, i.e. 17 edges after the first sample.
    task automatic wait_done(input string name);
        int n;
        int hit;
        hit = 0;
        for (n = 1; n <= 40 && hit == 0; n++) begin
            @(negedge clk);
            if (done === 1'b1) hit = n;
        end
        chk(name, hit, 2);
        chk("busy_after_done", int'(busy), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic run_search(input vec_t v);
        exp_q.push_back(v.expect_r);
        pulse_start();
        chk("busy_in_search", int'(busy), 1);
        drive_samples(v.fcode, v.mode, 16);
        wait_done("done_latency");
    endtask

    task automatic sweep(input logic [4:0] c);
        for (int x = 0; x < 16; x++) begin
            din = model_fwd(c, 4'(x));
            @(negedge clk);
            chk("roundtrip", int'(dout), x);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{fcode: 5'h0e, mode: 0, expect_r: '{f: 1'b1, a: 1'b0, c: 5'h0e}};
        vecs[1] = '{fcode: 5'h00, mode: 2, expect_r: '{f: 1'b0, a: 1'b0, c: 5'h0e}};
        vecs[2] = '{fcode: 5'h00, mode: 1, expect_r: '{f: 1'b0, a: 1'b1, c: 5'h00}};
        vecs[3] = '{fcode: 5'h17, mode: 0, expect_r: '{f: 1'b1, a: 1'b0, c: 5'h17}};
        vecs[4] = '{fcode: 5'h00, mode: 0, expect_r: '{f: 1'b1, a: 1'b0, c: 5'h00}};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_found", int'(found), 0);
        chk("rst_ambig", int'(ambig), 0);
        chk("rst_code", int'(code), 0);
        chk("rst_dout", int'(dout), 0);

        for (int i = 0; i < 5; i++) begin
            run_search(vecs[i]);
            if (vecs[i].expect_r.f) sweep(vecs[i].expect_r.c);
        end

        // Restart mid-search: the 0x05 samples and the sample coinciding
        // with the second start must have no effect.
        exp_q.push_back('{f: 1'b1, a: 1'b0, c: 5'h13});
        pulse_start();
        drive_samples(5'h05, 0, 8);
        set_sample(5'h05, 0, 8);
        sample_valid = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sample_valid = 1'b0;
        chk("busy_after_restart", int'(busy), 1);
        drive_samples(5'h13, 0, 16);
        wait_done("restart_latency");
        sweep(5'h13);

        // Reset mid-search: no done, reset values restored.
        pulse_start();
        drive_samples(5'h0e, 0, 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_code", int'(code), 0);
        chk("midrst_found", int'(found), 0);
        repeat (25) @(negedge clk);
        chk("midrst_no_pending", exp_q.size(), 0);

        run_search('{fcode: 5'h0e, mode: 0, expect_r: '{f: 1'b1, a: 1'b0, c: 5'h0e}});
        sweep(5'h0e);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
